// File: rtl/bbox_pkg.sv
// bbox_pkg: shared widths, the bounding-box result type and the cleared
// accumulator values for frame_bbox_extractor and its helpers.
//   HCOUNT_W/VCOUNT_W/PIXEL_W/COUNT_W : raster, pixel and counter widths
//   bbox_t                            : x, y, width, height of a box
//   *_CLR                             : accumulator values at the start of a frame
package bbox_pkg;

  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;
  localparam int PIXEL_W  = 12;
  localparam int COUNT_W  = 20;

  typedef struct packed {
    logic [HCOUNT_W-1:0] x;
    logic [VCOUNT_W-1:0] y;
    logic [HCOUNT_W-1:0] width;
    logic [VCOUNT_W-1:0] height;
  } bbox_t;

  // Min starts at all-ones and max at zero so the first match sets both.
  localparam logic [HCOUNT_W-1:0] MIN_X_CLR = '1;
  localparam logic [HCOUNT_W-1:0] MAX_X_CLR = '0;
  localparam logic [VCOUNT_W-1:0] MIN_Y_CLR = '1;
  localparam logic [VCOUNT_W-1:0] MAX_Y_CLR = '0;
  localparam logic [COUNT_W-1:0]  COUNT_CLR = '0;
  localparam logic [COUNT_W-1:0]  COUNT_MAX = '1;

  // Saturating increment of the match counter.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
    return (c == COUNT_MAX) ? c : c + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/bbox_axis_tracker.sv
// bbox_axis_tracker: running min/max of one coordinate axis over a frame.
//   clk_in, rst_n_in : clock, asynchronous active-low reset
//   sample_in        : coord_in is a matching pixel this cycle
//   coord_in         : coordinate of the sample
//   clear_in         : reload the cleared state at the next edge
//   min_out, max_out : running min/max INCLUDING this cycle's sample, so a
//                      caller snapshotting on clear_in captures the closing
//                      pixel as part of its frame.
module bbox_axis_tracker #(
  parameter int W = 11
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic         sample_in,
  input  logic [W-1:0] coord_in,
  input  logic         clear_in,
  output logic [W-1:0] min_out,
  output logic [W-1:0] max_out
);

  logic [W-1:0] min_q;
  logic [W-1:0] max_q;

  always_comb begin
    min_out = min_q;
    max_out = max_q;
    if (sample_in) begin
      if (coord_in < min_q) min_out = coord_in;
      if (coord_in > max_q) max_out = coord_in;
    end
  end

  // Cleared state is min = all-ones, max = zero.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      min_q <= '1;
      max_q <= '0;
    end else if (clear_in) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_out;
      max_q <= max_out;
    end
  end

endmodule

// File: rtl/frame_bbox_extractor.sv
// frame_bbox_extractor: recovers the bounding box of pixels matching a target
// colour in a scanned raster and reports it once per frame.
//   clk_in, rst_n_in        : clock, asynchronous active-low reset
//   hcount_in, vcount_in    : raster position of pixel_in
//   pixel_in                : RGB444 pixel
//   valid_in                : pixel/hcount/vcount qualify this cycle
//   frame_done_in           : one-cycle pulse with or after the frame's last pixel
//   x_out, y_out            : top-left of the box (0 when not found)
//   width_out, height_out   : box size (0 when not found)
//   pixel_count_out         : matching pixels in the frame, saturating
//   found_out               : pixel count reached MIN_PIXELS
//   valid_out               : one-cycle strobe when all results update
//
// Handshake: valid_in only qualifies the pixel; frame_done_in is honoured
// regardless of valid_in. There is no ready/backpressure: the pipeline
// advances every cycle and valid_out is a pure strobe appearing in the cycle
// after the second edge following the edge that samples frame_done_in.
// Results hold between strobes.
module frame_bbox_extractor
  import bbox_pkg::*;
#(
  parameter logic [PIXEL_W-1:0] COLOR      = 12'hFFF,
  parameter logic [PIXEL_W-1:0] MASK       = 12'hFFF,
  parameter int                 H_ACTIVE   = 1280,
  parameter int                 V_ACTIVE   = 720,
  parameter int                 MIN_PIXELS = 16
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [HCOUNT_W-1:0] hcount_in,
  input  logic [VCOUNT_W-1:0] vcount_in,
  input  logic [PIXEL_W-1:0]  pixel_in,
  input  logic                valid_in,
  input  logic                frame_done_in,
  output logic [HCOUNT_W-1:0] x_out,
  output logic [VCOUNT_W-1:0] y_out,
  output logic [HCOUNT_W-1:0] width_out,
  output logic [VCOUNT_W-1:0] height_out,
  output logic [COUNT_W-1:0]  pixel_count_out,
  output logic                found_out,
  output logic                valid_out
);

  // One extra bit so limits equal to 2**W (e.g. 2048) still compare correctly.
  localparam logic [HCOUNT_W:0]  H_LIM   = H_ACTIVE[HCOUNT_W:0];
  localparam logic [VCOUNT_W:0]  V_LIM   = V_ACTIVE[VCOUNT_W:0];
  localparam logic [COUNT_W-1:0] MIN_CNT = MIN_PIXELS[COUNT_W-1:0];

  // ---------------- Stage 1: colour match and raster window ----------------
  logic                match_d;
  logic                s1_match;
  logic [HCOUNT_W-1:0] s1_h;
  logic [VCOUNT_W-1:0] s1_v;
  logic                s1_done;

  assign match_d = valid_in
                 && (((pixel_in ^ COLOR) & MASK) == '0)
                 && ({1'b0, hcount_in} < H_LIM)
                 && ({1'b0, vcount_in} < V_LIM);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_match <= 1'b0;
      s1_h     <= '0;
      s1_v     <= '0;
      s1_done  <= 1'b0;
    end else begin
      s1_match <= match_d;
      s1_h     <= hcount_in;
      s1_v     <= vcount_in;
      s1_done  <= frame_done_in;
    end
  end

  // ---------------- Stage 2: accumulate and snapshot ----------------
  logic [HCOUNT_W-1:0] min_x, max_x;
  logic [VCOUNT_W-1:0] min_y, max_y;
  logic [COUNT_W-1:0]  count_q;
  logic [COUNT_W-1:0]  count_next;

  bbox_axis_tracker #(.W(HCOUNT_W)) u_x_tracker (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .sample_in (s1_match),
    .coord_in  (s1_h),
    .clear_in  (s1_done),
    .min_out   (min_x),
    .max_out   (max_x)
  );

  bbox_axis_tracker #(.W(VCOUNT_W)) u_y_tracker (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .sample_in (s1_match),
    .coord_in  (s1_v),
    .clear_in  (s1_done),
    .min_out   (min_y),
    .max_out   (max_y)
  );

  assign count_next = s1_match ? sat_inc(count_q) : count_q;

  logic [HCOUNT_W-1:0] snap_min_x, snap_max_x;
  logic [VCOUNT_W-1:0] snap_min_y, snap_max_y;
  logic [COUNT_W-1:0]  snap_count;
  logic                s2_done;

  // Snapshot takes the *_next values so a match coincident with frame_done
  // belongs to the closing frame; the counter restarts from zero.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      count_q    <= COUNT_CLR;
      snap_min_x <= MIN_X_CLR;
      snap_max_x <= MAX_X_CLR;
      snap_min_y <= MIN_Y_CLR;
      snap_max_y <= MAX_Y_CLR;
      snap_count <= COUNT_CLR;
      s2_done    <= 1'b0;
    end else begin
      s2_done <= s1_done;
      if (s1_done) begin
        snap_min_x <= min_x;
        snap_max_x <= max_x;
        snap_min_y <= min_y;
        snap_max_y <= max_y;
        snap_count <= count_next;
        count_q    <= COUNT_CLR;
      end else begin
        count_q <= count_next;
      end
    end
  end

  // ---------------- Stage 3: report ----------------
  logic  found_d;
  bbox_t box_d;
  bbox_t box_q;

  assign found_d = (snap_count >= MIN_CNT);

  always_comb begin
    box_d = '0;
    if (found_d) begin
      box_d.x      = snap_min_x;
      box_d.y      = snap_min_y;
      box_d.width  = snap_max_x - snap_min_x + HCOUNT_W'(1);
      box_d.height = snap_max_y - snap_min_y + VCOUNT_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      box_q           <= '0;
      pixel_count_out <= '0;
      found_out       <= 1'b0;
      valid_out       <= 1'b0;
    end else begin
      valid_out <= s2_done;
      if (s2_done) begin
        box_q           <= box_d;
        pixel_count_out <= snap_count;
        found_out       <= found_d;
      end
    end
  end

  assign x_out      = box_q.x;
  assign y_out      = box_q.y;
  assign width_out  = box_q.width;
  assign height_out = box_q.height;

endmodule

// File: tb/tb_frame_bbox_extractor.sv
// Testbench for frame_bbox_extractor. Two instances share one pixel stream:
// instance A uses the default colour/mask and MIN_PIXELS=16, instance B uses
// COLOR=MASK=12'hF00 and MIN_PIXELS=1. A reference model collects the matching
// coordinates of each frame and derives the report from them at frame_done.
module tb_frame_bbox_extractor;

  localparam logic [11:0] COLOR_A = 12'hFFF;
  localparam logic [11:0] MASK_A  = 12'hFFF;
  localparam int          MIN_A   = 16;
  localparam logic [11:0] COLOR_B = 12'hF00;
  localparam logic [11:0] MASK_B  = 12'hF00;
  localparam int          MIN_B   = 1;
  localparam int          EXP_W   = 96;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic [11:0] pixel = '0;
  logic        valid = 1'b0;
  logic        frame_done = 1'b0;

  logic [10:0] x_a, w_a, x_b, w_b;
  logic [9:0]  y_a, h_a, y_b, h_b;
  logic [19:0] cnt_a, cnt_b;
  logic        found_a, found_b, vo_a, vo_b;

  frame_bbox_extractor u_dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
    .pixel_in(pixel), .valid_in(valid), .frame_done_in(frame_done),
    .x_out(x_a), .y_out(y_a), .width_out(w_a), .height_out(h_a),
    .pixel_count_out(cnt_a), .found_out(found_a), .valid_out(vo_a)
  );

  frame_bbox_extractor #(
    .COLOR(COLOR_B), .MASK(MASK_B), .H_ACTIVE(1280), .V_ACTIVE(720), .MIN_PIXELS(MIN_B)
  ) u_dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
    .pixel_in(pixel), .valid_in(valid), .frame_done_in(frame_done),
    .x_out(x_b), .y_out(y_b), .width_out(w_b), .height_out(h_b),
    .pixel_count_out(cnt_b), .found_out(found_b), .valid_out(vo_b)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passed = 0;
  logic [EXP_W-1:0] exp_a_q[$];
  logic [EXP_W-1:0] exp_b_q[$];
  logic [EXP_W-1:0] last_a = '0;
  logic [EXP_W-1:0] last_b = '0;
  int ax_q[$], ay_q[$], bx_q[$], by_q[$];

  task automatic cmp(input string name, input logic [EXP_W-1:0] act, input logic [EXP_W-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Report layout: {pad, due_cycle[31:0], found, count[19:0], height, width, y, x}.
  function automatic logic [EXP_W-1:0] out_vec(input logic [10:0] x, input logic [9:0] y,
                                               input logic [10:0] w, input logic [9:0] h,
                                               input logic [19:0] c, input logic f);
    return {33'd0, f, c, h, w, y, x};
  endfunction

  function automatic bit model_match(input logic [11:0] color, input logic [11:0] mask,
                                     input logic [11:0] p, input int h, input int v, input bit vld);
    return vld && ((p & mask) == (color & mask)) && (h < 1280) && (v < 720);
  endfunction

  function automatic logic [EXP_W-1:0] make_report(input int xs[$], input int ys[$],
                                                   input int min_pix, input int due);
    int n, mnx, mxx, mny, mxy;
    logic f;
    logic [10:0] rx, rw;
    logic [9:0]  ry, rh;
    logic [19:0] c;
    logic [31:0] d;
    n = xs.size();
    mnx = 2047; mxx = 0; mny = 1023; mxy = 0;
    foreach (xs[i]) begin
      if (xs[i] < mnx) mnx = xs[i];
      if (xs[i] > mxx) mxx = xs[i];
      if (ys[i] < mny) mny = ys[i];
      if (ys[i] > mxy) mxy = ys[i];
    end
    f = (n >= min_pix);
    c = (n > 32'hFFFFF) ? 20'hFFFFF : n[19:0];
    rx = '0; ry = '0; rw = '0; rh = '0;
    if (f) begin
      rx = mnx[10:0];
      ry = mny[9:0];
      rw = 11'(mxx - mnx + 1);
      rh = 10'(mxy - mny + 1);
    end
    d = due;
    return {1'b0, d, f, c, rh, rw, ry, rx};
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (!rst_n) last_a = '0;
    else begin
      if (vo_a) begin
        if (exp_a_q.size() == 0) cmp("a_unexpected_strobe", 96'd1, 96'd0);
        else begin
          e = exp_a_q.pop_front();
          cmp("a_latency", 96'(cyc), 96'(e[94:63]));
          cmp("a_report", out_vec(x_a, y_a, w_a, h_a, cnt_a, found_a), {33'd0, e[62:0]});
          last_a = e;
        end
      end else begin
        cmp("a_hold", out_vec(x_a, y_a, w_a, h_a, cnt_a, found_a), {33'd0, last_a[62:0]});
      end
      if (exp_a_q.size() > 0 && int'(exp_a_q[0][94:63]) < cyc) begin
        e = exp_a_q.pop_front();
        cmp("a_missing_strobe", 96'd0, 96'(e[94:63]));
      end
    end
  end

  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (!rst_n) last_b = '0;
    else begin
      if (vo_b) begin
        if (exp_b_q.size() == 0) cmp("b_unexpected_strobe", 96'd1, 96'd0);
        else begin
          e = exp_b_q.pop_front();
          cmp("b_latency", 96'(cyc), 96'(e[94:63]));
          cmp("b_report", out_vec(x_b, y_b, w_b, h_b, cnt_b, found_b), {33'd0, e[62:0]});
          last_b = e;
        end
      end else begin
        cmp("b_hold", out_vec(x_b, y_b, w_b, h_b, cnt_b, found_b), {33'd0, last_b[62:0]});
      end
      if (exp_b_q.size() > 0 && int'(exp_b_q[0][94:63]) < cyc) begin
        e = exp_b_q.pop_front();
        cmp("b_missing_strobe", 96'd0, 96'(e[94:63]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Drives one cycle; the model updates at the moment the inputs are set,
  // and the report is due three edges later.
  task automatic drive(input int h, input int v, input logic [11:0] p, input bit vld, input bit done);
    hcount = h[10:0];
    vcount = v[9:0];
    pixel = p;
    valid = vld;
    frame_done = done;
    if (model_match(COLOR_A, MASK_A, p, h, v, vld)) begin ax_q.push_back(h); ay_q.push_back(v); end
    if (model_match(COLOR_B, MASK_B, p, h, v, vld)) begin bx_q.push_back(h); by_q.push_back(v); end
    if (done) begin
      exp_a_q.push_back(make_report(ax_q, ay_q, MIN_A, cyc + 3));
      exp_b_q.push_back(make_report(bx_q, by_q, MIN_B, cyc + 3));
      ax_q.delete(); ay_q.delete(); bx_q.delete(); by_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 12'h000, 1'b0, 1'b0);
  endtask

  task automatic noise();
    case ($urandom_range(0, 2))
      0: drive($urandom_range(0, 1279), $urandom_range(0, 719), 12'hFFF, 1'b0, 1'b0);
      1: drive($urandom_range(0, 2047), $urandom_range(0, 1023), 12'h000, 1'b1, 1'b0);
      default: drive(1280 + $urandom_range(0, 767), $urandom_range(0, 1023), 12'hFFF, 1'b1, 1'b0);
    endcase
  endtask

  task automatic box(input int ox, input int oy, input int w, input int h,
                     input logic [11:0] col, input int noise_pct);
    for (int j = 0; j < h; j++) begin
      for (int i = 0; i < w; i++) begin
        if ($urandom_range(0, 99) < noise_pct) noise();
        drive(ox + i, oy + j, col, 1'b1, 1'b0);
      end
    end
  endtask

  task automatic done_pulse();
    drive(0, 0, 12'h000, 1'b0, 1'b1);
  endtask

  task automatic check_zero(input string tag);
    cmp({tag, "_a"}, out_vec(x_a, y_a, w_a, h_a, cnt_a, found_a) | {vo_a, 95'd0}, '0);
    cmp({tag, "_b"}, out_vec(x_b, y_b, w_b, h_b, cnt_b, found_b) | {vo_b, 95'd0}, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [11:0] cols [4];
    cols[0] = 12'hFFF; cols[1] = 12'hF00; cols[2] = 12'hFAB; cols[3] = 12'h0F0;

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    rst_n = 1'b1;
    idle(3);

    // Solid rectangle 50x40 at (100,200) with sprinkled ignored pixels.
    box(100, 200, 50, 40, 12'hFFF, 5);
    done_pulse();
    idle(5);

    // All-black frame.
    for (int i = 0; i < 40; i++) drive($urandom_range(0, 1279), $urandom_range(0, 719), 12'h000, 1'b1, 1'b0);
    done_pulse();
    idle(5);

    // Out-of-window twins ignored; corner pixel coincident with frame_done.
    drive(1280, 719, 12'hFFF, 1'b1, 1'b0);
    drive(1279, 720, 12'hFFF, 1'b1, 1'b0);
    drive(1279, 719, 12'hFFF, 1'b1, 1'b1);
    idle(5);

    // Masked colour match (only instance B sees these).
    drive(10, 10, 12'hF12, 1'b1, 1'b0);
    drive(20, 30, 12'hF12, 1'b1, 1'b0);
    done_pulse();
    idle(5);

    // Frame A then frame B (B has exactly 16 pixels), then 15 pixels,
    // then back-to-back frame_done pulses.
    box(0, 0, 8, 8, 12'hFFF, 0);
    done_pulse();
    box(500, 400, 4, 4, 12'hFFF, 0);
    done_pulse();
    box(700, 100, 5, 3, 12'hFFF, 0);
    done_pulse();
    box(30, 40, 3, 2, 12'hFFF, 0);
    done_pulse();
    done_pulse();
    idle(5);

    // Random frames.
    for (int f = 0; f < 8; f++) begin
      box($urandom_range(0, 1276), $urandom_range(0, 716), $urandom_range(1, 8),
          $urandom_range(1, 8), cols[$urandom_range(0, 3)], 20);
      if ($urandom_range(0, 1) == 1)
        box($urandom_range(0, 1276), $urandom_range(0, 716), $urandom_range(1, 4),
            $urandom_range(1, 4), cols[$urandom_range(0, 3)], 10);
      done_pulse();
      idle($urandom_range(0, 4));
    end
    idle(5);

    // Reset mid-frame, asserted between clock edges.
    box(300, 100, 10, 10, 12'hFFF, 0);
    #2;
    rst_n = 1'b0;
    ax_q.delete(); ay_q.delete(); bx_q.delete(); by_q.delete();
    #1;
    check_zero("async_reset");
    repeat (3) @(posedge clk);
    #1;
    check_zero("held_reset");
    rst_n = 1'b1;
    idle(2);
    box(600, 50, 5, 4, 12'hFFF, 0);
    done_pulse();

    // Drain with a bounded wait.
    for (int i = 0; i < 20 && (exp_a_q.size() > 0 || exp_b_q.size() > 0); i++) idle(1);
    idle(2);
    cmp("drain_a", 96'(exp_a_q.size()), 96'd0);
    cmp("drain_b", 96'(exp_b_q.size()), 96'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
